// File: rtl/sdram_addr_pkg.sv
// Shared definitions for the SDRAM read-address path: sequencer state encoding,
// device geometry and default pointer widths.
package sdram_addr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } seq_state_e;

   // SDRAM device geometry
   localparam int BANK_W = 2;
   localparam int ROW_W  = 13;
   localparam int COL_W  = 9;
   localparam int DATA_W = 16;

   localparam int DEF_ADDR_W = 18;
   localparam int DEF_CS_W   = 1;

   localparam logic [7:0] WRAP_CNT_MAX = 8'hFF;

endpackage

// File: rtl/sdram_read_addr_sequencer_if.sv
// Control/status bundle between the readout controller (master) and the
// read-address sequencer (slave).
interface sdram_read_addr_sequencer_if
   import sdram_addr_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CS_W   = DEF_CS_W
);

   logic              START;
   logic              NEXT;
   logic              WRAP_MODE;
   logic [CS_W-1:0]   WR_CS;
   logic [ADDR_W-1:0] WR_ADDR;
   logic [ADDR_W-1:0] R_ADDRESS_OUT;
   logic [CS_W-1:0]   R_CHIP_SELECT;
   logic              R_VALID;
   logic              EMPTY;
   logic              DONE;
   logic [7:0]        WRAP_CNT;

   modport master (
      output START, NEXT, WRAP_MODE, WR_CS, WR_ADDR,
      input  R_ADDRESS_OUT, R_CHIP_SELECT, R_VALID, EMPTY, DONE, WRAP_CNT
   );

   modport slave (
      input  START, NEXT, WRAP_MODE, WR_CS, WR_ADDR,
      output R_ADDRESS_OUT, R_CHIP_SELECT, R_VALID, EMPTY, DONE, WRAP_CNT
   );

endinterface

// File: rtl/sdram_read_addr_sequencer_counter.sv
// linear_addr_counter: ADDR_W-wide counter stepping by STEP, with enable,
// synchronous clear and a combinational "next step overflows" flag.
module linear_addr_counter #(
   parameter int ADDR_W = 18,
   parameter int STEP   = 1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              en,
   input  logic              clr,
   output logic [ADDR_W-1:0] addr,
   output logic              ovf
);

   localparam logic [ADDR_W:0] STEP_INC = (ADDR_W + 1)'(STEP);

   logic [ADDR_W:0] sum;

   // One extra bit catches the carry out of the address field.
   assign sum = {1'b0, addr} + STEP_INC;
   assign ovf = sum[ADDR_W];

   // NOTE: sequential state is written only with non-blocking assignments so
   // every flop samples pre-edge values regardless of process ordering.
   always_ff @(posedge CLK) begin
      if (!RESET || clr) begin
         addr <= '0;
      end else if (en) begin
         addr <= sum[ADDR_W-1:0];
      end
   end

endmodule

// File: rtl/sdram_read_addr_sequencer.sv
// Read-address sequencer: walks {cs, address} across 2^CS_W devices with a
// start/halt FSM and wrap or stop-at-end. Optional overrun guard against the
// write pointer is enabled with `define SDRAM_READ_OVERRUN_GUARD_EN.
module sdram_read_addr_sequencer
   import sdram_addr_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CS_W   = DEF_CS_W,
   parameter int STEP   = 1
) (
   input logic CLK,
   input logic RESET,
   sdram_read_addr_sequencer_if.slave bus
);

   seq_state_e        state;
   seq_state_e        state_nxt;
   logic [ADDR_W-1:0] addr;
   logic              ovf;
   logic [CS_W-1:0]   cs;
   logic [7:0]        wrap_cnt;
   logic              empty;
   logic              last_cs;
   logic              advance;
   logic              halt_hit;
   logic              cnt_en;

`ifdef SDRAM_READ_OVERRUN_GUARD_EN
   assign empty = (state == ST_RUN) && ({cs, addr} == {bus.WR_CS, bus.WR_ADDR});
`else
   logic unused_wr;
   assign unused_wr = ^{bus.WR_CS, bus.WR_ADDR};
   assign empty     = 1'b0;
`endif

   // START outranks NEXT; the final overflow in stop mode freezes the pointer.
   assign last_cs  = (cs == {CS_W{1'b1}});
   assign advance  = (state == ST_RUN) && bus.NEXT && !empty && !bus.START;
   assign halt_hit = advance && ovf && last_cs && !bus.WRAP_MODE;
   assign cnt_en   = advance && !halt_hit;

   linear_addr_counter #(
      .ADDR_W (ADDR_W),
      .STEP   (STEP)
   ) u_addr_cnt (
      .CLK   (CLK),
      .RESET (RESET),
      .en    (cnt_en),
      .clr   (bus.START),
      .addr  (addr),
      .ovf   (ovf)
   );

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         cs       <= '0;
         wrap_cnt <= '0;
      end else if (bus.START) begin
         cs       <= '0;
         wrap_cnt <= '0;
      end else if (cnt_en && ovf) begin
         cs <= cs + CS_W'(1);
         if (last_cs && wrap_cnt != WRAP_CNT_MAX) begin
            wrap_cnt <= wrap_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (bus.START) state_nxt = ST_RUN;
         ST_RUN: begin
            if (bus.START)     state_nxt = ST_RUN;
            else if (halt_hit) state_nxt = ST_HALT;
         end
         ST_HALT: if (bus.START) state_nxt = ST_RUN;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.R_VALID = 1'b0;
      bus.DONE    = 1'b0;
      case (state)
         ST_RUN:  bus.R_VALID = 1'b1;
         ST_HALT: bus.DONE    = 1'b1;
         default: ;
      endcase
   end

   assign bus.R_ADDRESS_OUT = addr;
   assign bus.R_CHIP_SELECT = cs;
   assign bus.EMPTY         = empty;
   assign bus.WRAP_CNT      = wrap_cnt;

endmodule

// File: tb/tb_sdram_read_addr_sequencer.sv
// Scoreboard bench: stimulus pushes expected post-edge outputs, a negedge
// monitor pops and compares. Guard scenarios follow SDRAM_READ_OVERRUN_GUARD_EN.
module tb_sdram_read_addr_sequencer;

   typedef struct {
      int         tag;
      int         id;
      logic [3:0] a;
      logic       cs;
      logic       v;
      logic       d;
      logic [7:0] w;
      logic       ce;
      logic       e;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_pass;
   int   n_total;
   exp_t q[$];

   sdram_read_addr_sequencer_if #(.ADDR_W(4), .CS_W(1)) bus ();
   sdram_read_addr_sequencer_if #(.ADDR_W(4), .CS_W(1)) bus4 ();

   sdram_read_addr_sequencer #(.ADDR_W(4), .CS_W(1), .STEP(1)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   sdram_read_addr_sequencer #(.ADDR_W(4), .CS_W(1), .STEP(4)) dut4 (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic ok, input logic [31:0] act,
                        input logic [31:0] req);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   // Expected outputs after the next rising edge.
   function automatic void push(input int id, input logic [3:0] a, input logic cs,
                                input logic v, input logic d, input logic [7:0] w,
                                input logic ce, input logic e);
      exp_t x;
      x.tag = cyc + 1; x.id = id; x.a = a; x.cs = cs; x.v = v; x.d = d;
      x.w = w; x.ce = ce; x.e = e;
      q.push_back(x);
   endfunction

   function automatic void exp0(input int pos, input logic v, input logic d,
                                input int w, input logic ce, input logic e);
      push(0, 4'(pos % 16), 1'(pos / 16), v, d, 8'(w), ce, e);
   endfunction

   task automatic drv(input logic r, input logic st, input logic nx, input logic wm,
                      input int wr_pos);
      @(posedge clk);
      #1;
      rst           = r;
      bus.START     = st;
      bus.NEXT      = nx;
      bus.WRAP_MODE = wm;
      bus.WR_CS     = 1'(wr_pos / 16);
      bus.WR_ADDR   = 4'(wr_pos % 16);
   endtask

   task automatic drv4(input logic st, input logic nx);
      @(posedge clk);
      #1;
      bus.START  = 1'b0;
      bus.NEXT   = 1'b0;
      bus4.START = st;
      bus4.NEXT  = nx;
   endtask

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].tag <= cyc) begin
            exp_t x;
            logic [15:0] act;
            logic [15:0] req;
            x = q.pop_front();
            if (x.id == 0)
               act = {bus.R_ADDRESS_OUT, bus.R_CHIP_SELECT, bus.R_VALID, bus.DONE,
                      bus.WRAP_CNT, bus.EMPTY};
            else
               act = {bus4.R_ADDRESS_OUT, bus4.R_CHIP_SELECT, bus4.R_VALID, bus4.DONE,
                      bus4.WRAP_CNT, bus4.EMPTY};
            if (!x.ce) act[0] = x.e;
            req = {x.a, x.cs, x.v, x.d, x.w, x.e};
            check($sformatf("dut%0d_cyc%0d{addr,cs,valid,done,wcnt,empty}", x.id, x.tag),
                  (x.tag == cyc) && (act == req), 32'(act), 32'(req));
         end
      end
   end

   initial begin
      n_pass = 0;
      n_total = 0;
      rst = 1'b0;
      bus.START = 1'b0; bus.NEXT = 1'b0; bus.WRAP_MODE = 1'b0;
      bus.WR_CS = 1'b0; bus.WR_ADDR = 4'd0;
      bus4.START = 1'b0; bus4.NEXT = 1'b0; bus4.WRAP_MODE = 1'b1;
      bus4.WR_CS = 1'b1; bus4.WR_ADDR = 4'd8;

      // Reset state; NEXT ignored in IDLE; EMPTY low in IDLE despite pointer match
      drv(0, 0, 0, 0, 0);
      exp0(0, 0, 0, 0, 1, 0);
      push(1, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
      drv(1, 0, 1, 1, 0);
      exp0(0, 0, 0, 0, 1, 0);
      drv(1, 1, 0, 1, 8);
      exp0(0, 1, 0, 0, 1, 0);

      // 15 NEXTs to 15/0, then on through 0/1, 15/1 and wrap to 0/0
      for (int i = 1; i <= 33; i++) begin
         drv(1, 0, 1, 1, (i - 1 + 8) % 32);
         exp0(i % 32, 1, 0, (i >= 32) ? 1 : 0, 1, 0);
      end

      // Stop-at-end: START clears WRAP_CNT, 31 NEXTs to 15/1, then HALT
      drv(1, 1, 0, 0, 9);
      exp0(0, 1, 0, 0, 1, 0);
      for (int i = 1; i <= 31; i++) begin
         drv(1, 0, 1, 0, (i - 1 + 8) % 32);
         exp0(i, 1, 0, 0, 1, 0);
      end
      drv(1, 0, 1, 0, 7);
      exp0(31, 0, 1, 0, 1, 0);
      drv(1, 0, 1, 0, 7);
      exp0(31, 0, 1, 0, 1, 0);
      drv(1, 1, 0, 0, 7);
      exp0(0, 1, 0, 0, 1, 0);

      // START beats NEXT at address 7
      for (int i = 1; i <= 7; i++) begin
         drv(1, 0, 1, 0, (i - 1 + 8) % 32);
         exp0(i, 1, 0, 0, 1, 0);
      end
      drv(1, 1, 1, 0, 15);
      exp0(0, 1, 0, 0, 1, 0);

      // Reset mid-run at 9/1
      for (int i = 1; i <= 25; i++) begin
         drv(1, 0, 1, 0, (i - 1 + 8) % 32);
         exp0(i, 1, 0, 0, 1, 0);
      end
      drv(0, 0, 1, 0, 1);
      exp0(0, 0, 0, 0, 1, 0);
      drv(1, 0, 1, 0, 0);
      exp0(0, 0, 0, 0, 1, 0);

`ifdef SDRAM_READ_OVERRUN_GUARD_EN
      // Write pointer at 0/3: NEXT held stalls at 3 with EMPTY high
      drv(1, 1, 0, 1, 3);
      exp0(0, 1, 0, 0, 1, 0);
      for (int k = 1; k <= 5; k++) begin
         drv(1, 0, 1, 1, 3);
         exp0((k < 3) ? k : 3, 1, 0, 0, (k != 5), (k >= 3));
      end
      // Write pointer moves to 0/5: advance to 5, then stall again
      for (int k = 1; k <= 4; k++) begin
         drv(1, 0, 1, 1, 5);
         exp0((k < 2) ? 3 + k : 5, 1, 0, 0, (k != 4), (k >= 2));
      end
`else
      // Without the guard, a matching write pointer neither blocks nor raises EMPTY
      drv(1, 1, 0, 0, 0);
      exp0(0, 1, 0, 0, 1, 0);
      for (int i = 1; i <= 3; i++) begin
         drv(1, 0, 1, 0, i - 1);
         exp0(i, 1, 0, 0, 1, 0);
      end
`endif

      // STEP=4 instance: 0, 4, 8, 12, then 0 on device 1
      drv4(1, 0);
      push(1, 4'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         drv4(0, 1);
         push(1, 4'((k * 4) % 16), 1'(k / 4), 1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
      end
      drv4(0, 0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check("queue_drained", q.size() == 0, 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sdram_read_addr_sequencer.md
# sdram_read_addr_sequencer

Parametrised read-address generator for the SDRAM logging path. It walks a linear address space across one or more SDRAM devices and presents the current read address and chip select to the SDRAM controller. It sits between the downlink/readout control logic (which issues NEXT requests) and the SDRAM read port. Compared with the earlier free-running counter, it adds a synchronous clock domain, an explicit start/halt state machine, a selectable wrap or stop-at-end mode, and optional overrun protection against the write pointer.

## Interface
Parameters:
- ADDR_W, 18: address bits per device.
- CS_W, 1: chip-select bits; number of devices = 2^CS_W.
- STEP, 1: address increment per NEXT. Must be a power of two and ≤ 2^(ADDR_W-1).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-low reset.
- START  in  1  single-cycle pulse; (re)starts traversal at device 0, address 0.
- NEXT  in  1  advance request, sampled every cycle it is high.
- WRAP_MODE  in  1  1 = wrap from the last device to device 0; 0 = halt at the end.
- WR_CS  in  CS_W  current write-pointer chip select (overrun guard).
- WR_ADDR  in  ADDR_W  current write-pointer address (overrun guard).
- R_ADDRESS_OUT  out  ADDR_W  current read address.
- R_CHIP_SELECT  out  CS_W  current device index.
- R_VALID  out  1  address outputs are valid (state RUN).
- EMPTY  out  1  read pointer equals write pointer; NEXT is blocked.
- DONE  out  1  traversal finished (state HALT).
- WRAP_CNT  out  8  number of full-space wraps, saturating at 255.

## Operation
- States: IDLE, RUN, HALT.
- Reset (RESET=0 at a clock edge):
  - state ← IDLE; R_ADDRESS_OUT=0, R_CHIP_SELECT=0, R_VALID=0, DONE=0, WRAP_CNT=0.
  - EMPTY=0 while in IDLE.
  - Reset overrides every other input, including a traversal in progress.
- IDLE:
  - START → RUN; address 0, cs 0.
  - NEXT is ignored.
- RUN:
  - R_VALID=1.
  - START has priority over NEXT: address, cs and WRAP_CNT are cleared, state stays RUN.
  - NEXT && !EMPTY → address ← address + STEP (modulo 2^ADDR_W).
  - When address + STEP overflows ADDR_W:
    - address ← 0.
    - If cs < 2^CS_W-1: cs ← cs+1.
    - If cs = 2^CS_W-1 and WRAP_MODE=1: cs ← 0; WRAP_CNT increments, saturating at 255.
    - If cs = 2^CS_W-1 and WRAP_MODE=0: state ← HALT; address and cs hold their last values.
- HALT:
  - R_VALID=0, DONE=1.
  - NEXT is ignored.
  - START → RUN at 0/0 and clears DONE.
- EMPTY = (state==RUN) && ({R_CHIP_SELECT,R_ADDRESS_OUT} == {WR_CS,WR_ADDR}).
- WRAP_MODE is sampled only at the overflow event. Changing it mid-run is legal.

## Timing
- All outputs except EMPTY are registered. An accepted NEXT at edge n updates the address and cs outputs after edge n.
- Latency: 1 cycle from START or NEXT to the new address.
- NEXT held high for k cycles in RUN, with no EMPTY, gives k advances (one per cycle).
- EMPTY is combinational from the internal registers and WR_CS/WR_ADDR. It gates NEXT in the same cycle.
- The transition to HALT takes effect 1 cycle after the final NEXT; DONE asserts on that same edge.

## Configuration
- Macro: SDRAM_READ_OVERRUN_GUARD_EN.
- Defined: EMPTY is computed as above and blocks NEXT.
- Undefined:
  - EMPTY is tied 0.
  - WR_CS and WR_ADDR remain ports but are ignored.
  - NEXT always advances while in RUN.

## Structure
- Shared package sdram_addr_pkg:
  - State encoding (IDLE/RUN/HALT).
  - SDRAM geometry constants: BANK_W=2, ROW_W=13, COL_W=9, DATA_W=16.
  - Default ADDR_W/CS_W values.
- One sub-module, linear_addr_counter: ADDR_W-wide, STEP-increment counter with enable, synchronous clear, and a registered-free overflow flag.
- The top level holds the FSM, cs counter, wrap counter and empty compare.

## Test plan
All scenarios use ADDR_W=4, CS_W=1, STEP=1 unless stated.

- Reset then START → R_VALID=1, address 0, cs 0. A further 15 NEXT pulses → address 15, cs 0.
- WRAP_MODE=1, 32 NEXTs from 0/0 → passes 15/0 → 0/1 → 15/1 → 0/0; WRAP_CNT=1.
- WRAP_MODE=0, 31 NEXTs then 1 more → outputs stay 15/1, DONE=1, R_VALID=0. Further NEXT has no effect. START → 0/0, DONE=0.
- Guard enabled, WR_CS=0, WR_ADDR=3, NEXT held high → address stops at 3, EMPTY=1. WR_ADDR=5 → advances to 5, then blocks.
- START and NEXT in the same cycle at address 7 → address 0, not 1. RESET low mid-run at 9/1 → 0/0, IDLE, R_VALID=0 after the edge.
- STEP=4: 4 NEXTs → address 0, 4, 8, 12, then 0 with cs=1.
